// File: rtl/jtcontra_snd_cmd.sv
// Sound command bridge: queues main-CPU latch writes and interrupts the sound CPU once per byte.
// Latency: a push is visible on level/snd_dout at the sampling edge; snd_irqn falls one edge later.
// Backpressure: none upstream; pushes into a full queue are dropped and flagged on the sticky ovf.
module jtcontra_snd_cmd #(
  parameter int AW      = 2,
  parameter int GAP_CYC = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          snd_cen,
  input  logic          main_irq,
  input  logic [7:0]    main_latch,
  input  logic          snd_rd,
  input  logic          snd_ack,
  output logic [7:0]    snd_dout,
  output logic          snd_irqn,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] GAP_INIT = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SERV, S_GAP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_dout;
  logic          r_ovf;
  logic          r_main_prev;
  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic          w_push_req, w_full, w_empty, w_pop, w_push;
  logic [AW-1:0] w_rd_nxt, w_wr_nxt;
  logic [AW:0]   w_level_nxt;
  logic [7:0]    w_dout_nxt;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_push_req = main_irq & ~r_main_prev;
  assign w_full     = (r_level == FULL_LVL);
  assign w_empty    = (r_level == '0);
  assign w_pop      = snd_rd & snd_cen & ~w_empty;
  // A full queue still accepts a byte when a pop frees a slot in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign w_rd_nxt    = w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_wr_nxt    = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_level_nxt = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // Next head byte: bypass the incoming byte if it lands in the head slot; hold the last byte once empty.
  always_comb begin
    w_dout_nxt = r_dout;
    if (w_level_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_nxt)) w_dout_nxt = main_latch;
      else                                  w_dout_nxt = r_mem[w_rd_nxt];
    end
  end

  // Queue storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= main_latch;
  end

  // Queue pointers, occupancy, head register, overflow flag and edge detector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
      r_main_prev <= 1'b0;
    end else begin
      r_main_prev <= main_irq;
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_level     <= w_level_nxt;
      r_dout      <= w_dout_nxt;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // IRQ state register and gap counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // IRQ next state: a pop always ends the interrupt (even while polling), then a gap precedes the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_PEND;
      S_PEND: begin
        if (w_pop) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = GAP_INIT;
        end else if (snd_ack && snd_cen) begin
          w_state_nxt = S_SERV;
        end
      end
      S_SERV: begin
        if (w_pop) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = GAP_INIT;
        end
      end
      S_GAP: begin
        if (snd_cen) begin
          if (r_cnt == '0) w_state_nxt = S_IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign snd_irqn = (r_state != S_PEND);
  assign snd_dout = r_dout;
  assign level    = r_level;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_jtcontra_snd_cmd.sv
// Directed bench for the sound command bridge: reset, single, burst, overflow, wrap, async reset.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
// Every comparison goes through chk and feeds the summary counts.
module tb_jtcontra_snd_cmd;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       snd_cen = 1'b1;
  logic       main_irq = 1'b0;
  logic [7:0] main_latch = 8'h00;
  logic       snd_rd = 1'b0;
  logic       snd_ack = 1'b0;
  logic [7:0] snd_dout;
  logic       snd_irqn;
  logic [2:0] level;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  jtcontra_snd_cmd #(.AW(2), .GAP_CYC(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .snd_cen    (snd_cen),
    .main_irq   (main_irq),
    .main_latch (main_latch),
    .snd_rd     (snd_rd),
    .snd_ack    (snd_ack),
    .snd_dout   (snd_dout),
    .snd_irqn   (snd_irqn),
    .level      (level),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; leaves main_irq low so the next push needs another tick first.
  task automatic push(input logic [7:0] b);
    main_latch = b;
    main_irq   = 1'b1;
    tick();
    main_irq   = 1'b0;
  endtask

  task automatic pop();
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
  endtask

  task automatic ack();
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] burst [3];
    logic [7:0] ovfq [4];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    ovfq[0] = 8'h02; ovfq[1] = 8'h03; ovfq[2] = 8'h04; ovfq[3] = 8'h66;

    // 1: reset release
    do_reset();
    chk("rst_irqn",  {15'd0, snd_irqn}, 16'd1);
    chk("rst_dout",  {8'd0, snd_dout},  16'h00);
    chk("rst_level", {13'd0, level},    16'd0);
    chk("rst_ovf",   {15'd0, ovf},      16'd0);

    // 2: single command
    push(8'h5A);
    chk("s_level", {13'd0, level},    16'd1);
    chk("s_dout",  {8'd0, snd_dout},  16'h5A);
    chk("s_irqn0", {15'd0, snd_irqn}, 16'd1);
    tick();
    chk("s_irqn1", {15'd0, snd_irqn}, 16'd0);
    ack();
    chk("s_ackirqn", {15'd0, snd_irqn}, 16'd1);
    pop();
    chk("s_poplvl",  {13'd0, level},    16'd0);
    chk("s_popdout", {8'd0, snd_dout},  16'h5A);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s_gapirqn", {15'd0, snd_irqn}, 16'd1);
    end

    // 3: burst of three, one IRQ per byte with a gap between
    push(8'h11); tick();
    push(8'h22); tick();
    push(8'h33);
    chk("b_level", {13'd0, level}, 16'd3);
    for (int r = 0; r < 3; r++) begin
      chk("b_irqn",  {15'd0, snd_irqn}, 16'd0);
      chk("b_dout",  {8'd0, snd_dout},  {8'd0, burst[r]});
      ack();
      chk("b_srvirqn", {15'd0, snd_irqn}, 16'd1);
      pop();
      chk("b_level", {13'd0, level}, 16'(2 - r));
      for (int g = 0; g < 4; g++) begin
        tick();
        chk("b_gapirqn", {15'd0, snd_irqn}, 16'd1);
      end
      tick();
      chk("b_rearm", {15'd0, snd_irqn}, (r < 2) ? 16'd0 : 16'd1);
    end

    // 4: overflow, push+pop while full, cen-gated read
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push(8'(i)); tick();
    end
    chk("o_level4", {13'd0, level}, 16'd4);
    chk("o_ovf0",   {15'd0, ovf},   16'd0);
    main_latch = 8'h66; main_irq = 1'b1; snd_rd = 1'b1;
    tick();
    main_irq = 1'b0; snd_rd = 1'b0;
    chk("o_pp_level", {13'd0, level},   16'd4);
    chk("o_pp_ovf",   {15'd0, ovf},     16'd0);
    chk("o_pp_dout",  {8'd0, snd_dout}, 16'h02);
    tick();
    push(8'h77);
    chk("o_drop_level", {13'd0, level}, 16'd4);
    chk("o_ovf1",       {15'd0, ovf},   16'd1);
    snd_cen = 1'b0; snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0; snd_cen = 1'b1;
    chk("o_cen0_level", {13'd0, level}, 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk("o_rd", {8'd0, snd_dout}, {8'd0, ovfq[i]});
      pop();
    end
    chk("o_empty", {13'd0, level},   16'd0);
    chk("o_hold",  {8'd0, snd_dout}, 16'h66);
    pop();
    chk("o_popempty_lvl",  {13'd0, level},   16'd0);
    chk("o_popempty_dout", {8'd0, snd_dout}, 16'h66);
    chk("o_ovf_sticky",    {15'd0, ovf},     16'd1);

    // 5: pointer wrap, plus push+pop on empty
    do_reset();
    for (int v = 0; v < 10; v++) begin
      push(8'(v));
      chk("w_dout", {8'd0, snd_dout}, 16'(v));
      pop();
      chk("w_level", {13'd0, level}, 16'd0);
    end
    main_latch = 8'hAB; main_irq = 1'b1; snd_rd = 1'b1;
    tick();
    main_irq = 1'b0; snd_rd = 1'b0;
    chk("e_pp_level", {13'd0, level},   16'd1);
    chk("e_pp_dout",  {8'd0, snd_dout}, 16'hAB);
    pop();
    chk("e_level", {13'd0, level}, 16'd0);

    // 6: async reset with bytes queued and IRQ pending
    do_reset();
    push(8'hA1); tick();
    push(8'hA2); tick();
    push(8'hA3);
    chk("r_level3", {13'd0, level},    16'd3);
    chk("r_irqn0",  {15'd0, snd_irqn}, 16'd0);
    #2 rstn = 1'b0;
    #1;
    chk("r_irqn",  {15'd0, snd_irqn}, 16'd1);
    chk("r_dout",  {8'd0, snd_dout},  16'h00);
    chk("r_level", {13'd0, level},    16'd0);
    chk("r_ovf",   {15'd0, ovf},      16'd0);
    tick();
    rstn = 1'b1;
    tick();
    push(8'hC3);
    chk("r_c3_dout",  {8'd0, snd_dout}, 16'hC3);
    chk("r_c3_level", {13'd0, level},   16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
